// File: rtl/conv_addr_seq.sv
// conv_addr_seq: self-sequencing IFM/weight address generator
// walks oc/r/c/ic/i/j and schedules MAC clear and output writes
`timescale 1ns/1ps
module conv_addr_seq #(
  parameter int IN_SIZE  = 4,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int PAD      = 0,
  parameter int IN_CH    = 1,
  parameter int OUT_CH   = 1,
  parameter int ADDR_W   = 8,
  parameter int PIPE_DLY = 9
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic              pad_zero,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              acc_clr,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] out_chan_idx
);

  localparam int OUT_SIZE = (IN_SIZE + 2*PAD - K)/STRIDE + 1;
  localparam int W  = ADDR_W + 2;
  localparam int DW = $clog2(PIPE_DLY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OC_MAX = ADDR_W'(OUT_CH - 1);
  localparam logic [ADDR_W-1:0] RC_MAX = ADDR_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] IC_MAX = ADDR_W'(IN_CH - 1);
  localparam logic [ADDR_W-1:0] K_MAX  = ADDR_W'(K - 1);
  localparam logic [DW-1:0]     DR_MAX = DW'(PIPE_DLY - 1);

  localparam logic [ADDR_W-1:0] A_IN  = ADDR_W'(IN_SIZE);
  localparam logic [ADDR_W-1:0] A_IN2 = ADDR_W'(IN_SIZE*IN_SIZE);
  localparam logic [ADDR_W-1:0] A_K   = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] A_ICH = ADDR_W'(IN_CH);
  localparam logic [ADDR_W-1:0] A_OS  = ADDR_W'(OUT_SIZE);
  localparam logic [ADDR_W-1:0] A_OS2 = ADDR_W'(OUT_SIZE*OUT_SIZE);

  localparam logic signed [W-1:0] S_STR = W'(STRIDE);
  localparam logic signed [W-1:0] S_PAD = W'(PAD);
  localparam logic signed [W-1:0] S_IN  = W'(IN_SIZE);

  logic [1:0]        state_q;
  logic [DW-1:0]     drain_q;
  logic [ADDR_W-1:0] oc_q, r_q, c_q, ic_q, i_q, j_q;

  logic issue;
  logic j_end, i_end, ic_end, c_end, r_end, oc_end;
  logic last_px, last_all, first_px;

  assign issue    = (state_q == S_RUN) && !hold;
  assign j_end    = (j_q == K_MAX);
  assign i_end    = (i_q == K_MAX);
  assign ic_end   = (ic_q == IC_MAX);
  assign c_end    = (c_q == RC_MAX);
  assign r_end    = (r_q == RC_MAX);
  assign oc_end   = (oc_q == OC_MAX);
  assign last_px  = ic_end && i_end && j_end;
  assign last_all = last_px && c_end && r_end && oc_end;
  assign first_px = (ic_q == '0) && (i_q == '0) && (j_q == '0);

  logic signed [W-1:0] row, col;
  logic                in_pad;
  logic [ADDR_W-1:0]   ifm_nxt, wgt_nxt, oadr_nxt;

  assign row = $signed({2'b00, r_q}) * S_STR
             + $signed({2'b00, i_q}) - S_PAD;
  assign col = $signed({2'b00, c_q}) * S_STR
             + $signed({2'b00, j_q}) - S_PAD;
  assign in_pad = row[W-1] || col[W-1]
               || (row >= S_IN) || (col >= S_IN);

  assign ifm_nxt  = ic_q * A_IN2
                  + row[ADDR_W-1:0] * A_IN
                  + col[ADDR_W-1:0];
  assign wgt_nxt  = ((oc_q * A_ICH + ic_q) * A_K + i_q) * A_K + j_q;
  assign oadr_nxt = oc_q * A_OS2 + r_q * A_OS + c_q;

  // layer control: idle -> run -> drain -> done
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_q <= S_RUN;
        S_RUN: begin
          if (issue && last_all) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_q == DR_MAX) state_q <= S_DONE;
          else drain_q <= drain_q + DW'(1);
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // nested loop counters, j innermost, oc outermost
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      {oc_q, r_q, c_q, ic_q, i_q, j_q} <= '0;
    end else if (state_q == S_IDLE && start) begin
      {oc_q, r_q, c_q, ic_q, i_q, j_q} <= '0;
    end else if (issue) begin
      j_q <= j_end ? '0 : j_q + ONE;
      if (j_end)
        i_q <= i_end ? '0 : i_q + ONE;
      if (j_end && i_end)
        ic_q <= ic_end ? '0 : ic_q + ONE;
      if (last_px)
        c_q <= c_end ? '0 : c_q + ONE;
      if (last_px && c_end)
        r_q <= r_end ? '0 : r_q + ONE;
      if (last_px && c_end && r_end)
        oc_q <= oc_end ? '0 : oc_q + ONE;
    end
  end

  logic              tv_q, pz_q, clr_q, last_q;
  logic [ADDR_W-1:0] ifm_q, wgt_q, oadr_q, ocr_q;

  // registered tap outputs, cleared on idle cycles
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tv_q   <= 1'b0;
      pz_q   <= 1'b0;
      clr_q  <= 1'b0;
      last_q <= 1'b0;
      ifm_q  <= '0;
      wgt_q  <= '0;
      oadr_q <= '0;
      ocr_q  <= '0;
    end else begin
      tv_q   <= issue;
      pz_q   <= issue && in_pad;
      clr_q  <= issue && first_px;
      last_q <= issue && last_px;
      ifm_q  <= (issue && !in_pad) ? ifm_nxt : '0;
      wgt_q  <= issue ? wgt_nxt : '0;
      oadr_q <= issue ? oadr_nxt : '0;
      ocr_q  <= issue ? oc_q : '0;
    end
  end

  logic [PIPE_DLY-1:0]             dl_we;
  logic [PIPE_DLY-1:0][ADDR_W-1:0] dl_addr;
  logic [PIPE_DLY-1:0][ADDR_W-1:0] dl_oc;

  // write strobe delay line, shifts even while hold is high
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dl_we   <= '0;
      dl_addr <= '0;
      dl_oc   <= '0;
    end else begin
      dl_we[0]   <= tv_q && last_q;
      dl_addr[0] <= oadr_q;
      dl_oc[0]   <= ocr_q;
      for (int k = PIPE_DLY - 1; k > 0; k--) begin
        dl_we[k]   <= dl_we[k-1];
        dl_addr[k] <= dl_addr[k-1];
        dl_oc[k]   <= dl_oc[k-1];
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign tap_valid    = tv_q;
  assign ifm_addr     = ifm_q;
  assign pad_zero     = pz_q;
  assign weight_addr  = wgt_q;
  assign acc_clr      = clr_q;
  assign out_we       = dl_we[PIPE_DLY-1];
  assign out_addr     = dl_addr[PIPE_DLY-1];
  assign out_chan_idx = dl_oc[PIPE_DLY-1];

endmodule

// File: tb/tb_conv_addr_seq.sv
// tb_conv_addr_seq: loop-nest model vs four conv_addr_seq configs
// plus literal timing/address expectations
`timescale 1ns/1ps
module tb_conv_addr_seq;

  localparam int PD = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       st[4], hd[4], rn[4];
  logic       tv[4], bz[4], dn[4], pz[4], cl[4], we[4];
  logic [7:0] ia[4], wa[4], oa[4], oci[4];

  int checks = 0;
  int failures = 0;

  conv_addr_seq u0 (
    .clock(clk), .rst_n(rn[0]), .start(st[0]), .hold(hd[0]),
    .busy(bz[0]), .done(dn[0]), .tap_valid(tv[0]),
    .ifm_addr(ia[0]), .pad_zero(pz[0]), .weight_addr(wa[0]),
    .acc_clr(cl[0]), .out_we(we[0]), .out_addr(oa[0]),
    .out_chan_idx(oci[0]));

  conv_addr_seq #(.PAD(1)) u1 (
    .clock(clk), .rst_n(rn[1]), .start(st[1]), .hold(hd[1]),
    .busy(bz[1]), .done(dn[1]), .tap_valid(tv[1]),
    .ifm_addr(ia[1]), .pad_zero(pz[1]), .weight_addr(wa[1]),
    .acc_clr(cl[1]), .out_we(we[1]), .out_addr(oa[1]),
    .out_chan_idx(oci[1]));

  conv_addr_seq #(.STRIDE(2), .IN_SIZE(5)) u2 (
    .clock(clk), .rst_n(rn[2]), .start(st[2]), .hold(hd[2]),
    .busy(bz[2]), .done(dn[2]), .tap_valid(tv[2]),
    .ifm_addr(ia[2]), .pad_zero(pz[2]), .weight_addr(wa[2]),
    .acc_clr(cl[2]), .out_we(we[2]), .out_addr(oa[2]),
    .out_chan_idx(oci[2]));

  conv_addr_seq #(.IN_CH(2), .OUT_CH(2)) u3 (
    .clock(clk), .rst_n(rn[3]), .start(st[3]), .hold(hd[3]),
    .busy(bz[3]), .done(dn[3]), .tap_valid(tv[3]),
    .ifm_addr(ia[3]), .pad_zero(pz[3]), .weight_addr(wa[3]),
    .acc_clr(cl[3]), .out_we(we[3]), .out_addr(oa[3]),
    .out_chan_idx(oci[3]));

  typedef struct {
    int ifm; int pad; int wgt; int clr; int last; int oa; int oc;
  } tap_t;
  typedef struct { int cyc; int oa; int oc; } wr_t;

  tap_t eq[$];
  int o_ifm[$], o_pad[$], o_wgt[$];
  int c_cyc[$], w_cyc[$], w_addr[$], w_ch[$];
  int d_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic zero_chk(input int id, input string tag);
    chk({tag, "_tap_valid"}, int'(tv[id]), 0);
    chk({tag, "_busy"}, int'(bz[id]), 0);
    chk({tag, "_done"}, int'(dn[id]), 0);
    chk({tag, "_pad_zero"}, int'(pz[id]), 0);
    chk({tag, "_acc_clr"}, int'(cl[id]), 0);
    chk({tag, "_out_we"}, int'(we[id]), 0);
    chk({tag, "_ifm_addr"}, int'(ia[id]), 0);
    chk({tag, "_weight_addr"}, int'(wa[id]), 0);
    chk({tag, "_out_addr"}, int'(oa[id]), 0);
    chk({tag, "_out_chan"}, int'(oci[id]), 0);
  endtask

  // behavioural model: full loop nest straight from the address rules
  task automatic gen(input int insz, input int k, input int s,
                     input int p, input int ich, input int och);
    int os;
    os = (insz + 2*p - k)/s + 1;
    eq.delete();
    for (int oc = 0; oc < och; oc++)
    for (int r = 0; r < os; r++)
    for (int c = 0; c < os; c++)
    for (int ic = 0; ic < ich; ic++)
    for (int i = 0; i < k; i++)
    for (int j = 0; j < k; j++) begin
      tap_t t;
      int row, col;
      row = r*s + i - p;
      col = c*s + j - p;
      t.pad = (row < 0 || col < 0 || row >= insz || col >= insz) ? 1 : 0;
      t.ifm = t.pad ? 0 : ic*insz*insz + row*insz + col;
      t.wgt = ((oc*ich + ic)*k + i)*k + j;
      t.clr = (ic == 0 && i == 0 && j == 0) ? 1 : 0;
      t.last = (ic == ich-1 && i == k-1 && j == k-1) ? 1 : 0;
      t.oa = oc*os*os + r*os + c;
      t.oc = oc;
      eq.push_back(t);
    end
  endtask

  task automatic run_layer(input int id, input int insz, input int k,
                           input int s, input int p, input int ich,
                           input int och, input int hold_at,
                           input int abort_at);
    int total, ti, done_exp, budget, n;
    bit exp_tv, exp_we, held, fin;
    wr_t wq[$];
    gen(insz, k, s, p, ich, och);
    total = eq.size();
    o_ifm.delete(); o_pad.delete(); o_wgt.delete();
    c_cyc.delete(); w_cyc.delete(); w_addr.delete(); w_ch.delete();
    d_cyc = -1;
    ti = 0;
    done_exp = -1;
    fin = 0;
    budget = total + PD + 30;
    @(negedge clk);
    st[id] = 1'b1;
    @(negedge clk);
    st[id] = 1'b0;
    for (n = 0; n < budget; n++) begin
      held = (hold_at > 0 && n >= hold_at && n < hold_at + 5);
      exp_tv = (n >= 1) && !held && (ti < total);
      chk("tap_valid", int'(tv[id]), int'(exp_tv));
      if (tv[id]) begin
        o_ifm.push_back(int'(ia[id]));
        o_pad.push_back(int'(pz[id]));
        o_wgt.push_back(int'(wa[id]));
      end
      if (cl[id]) c_cyc.push_back(n);
      if (we[id]) begin
        w_cyc.push_back(n);
        w_addr.push_back(int'(oa[id]));
        w_ch.push_back(int'(oci[id]));
      end
      if (dn[id]) d_cyc = n;
      if (exp_tv) begin
        chk("ifm_addr", int'(ia[id]), eq[ti].ifm & 255);
        chk("pad_zero", int'(pz[id]), eq[ti].pad);
        chk("weight_addr", int'(wa[id]), eq[ti].wgt & 255);
        chk("acc_clr", int'(cl[id]), eq[ti].clr);
        if (eq[ti].last) wq.push_back('{n + PD, eq[ti].oa, eq[ti].oc});
        if (ti == total - 1) done_exp = n + PD;
        ti++;
      end else begin
        chk("acc_clr_idle", int'(cl[id]), 0);
      end
      exp_we = (wq.size() > 0) && (wq[0].cyc == n);
      chk("out_we", int'(we[id]), int'(exp_we));
      if (exp_we) begin
        chk("out_addr", int'(oa[id]), wq[0].oa & 255);
        chk("out_chan_idx", int'(oci[id]), wq[0].oc & 255);
        void'(wq.pop_front());
      end
      chk("done", int'(dn[id]), int'(n == done_exp));
      chk("busy", int'(bz[id]), int'(done_exp < 0 || n <= done_exp));
      if (n == abort_at) begin
        rn[id] = 1'b0;
        #1;
        zero_chk(id, "abort_async");
        @(negedge clk);
        @(negedge clk);
        rn[id] = 1'b1;
        repeat (25) begin
          @(negedge clk);
          chk("abort_out_we", int'(we[id]), 0);
          chk("abort_done", int'(dn[id]), 0);
          chk("abort_busy", int'(bz[id]), 0);
          chk("abort_tap_valid", int'(tv[id]), 0);
        end
        return;
      end
      if (done_exp >= 0 && n == done_exp + 2) begin
        fin = 1;
        break;
      end
      hd[id] = (hold_at > 0 && n + 1 >= hold_at && n + 1 < hold_at + 5);
      @(negedge clk);
    end
    hd[id] = 1'b0;
    chk("run_completed", int'(fin), 1);
    chk("pending_writes", wq.size(), 0);
  endtask

  // hand-computed expectations for the 4x4/K3 default layer
  task automatic lit_default(input int sh);
    int e_ifm[9];
    e_ifm = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    chk("lit_tap_count", o_ifm.size(), 36);
    for (int k = 0; k < 9; k++)
      chk("lit_ifm_first9", qat(o_ifm, k), e_ifm[k]);
    chk("lit_clr_count", c_cyc.size(), 4);
    chk("lit_clr0", qat(c_cyc, 0), 1);
    chk("lit_clr1", qat(c_cyc, 1), 10);
    chk("lit_clr2", qat(c_cyc, 2), 19 + sh);
    chk("lit_clr3", qat(c_cyc, 3), 28 + sh);
    chk("lit_we_count", w_cyc.size(), 4);
    chk("lit_we0_cyc", qat(w_cyc, 0), 9 + PD);
    chk("lit_we1_cyc", qat(w_cyc, 1), 18 + PD + sh);
    chk("lit_we2_cyc", qat(w_cyc, 2), 27 + PD + sh);
    chk("lit_we3_cyc", qat(w_cyc, 3), 36 + PD + sh);
    for (int k = 0; k < 4; k++)
      chk("lit_we_addr", qat(w_addr, k), k);
    chk("lit_done_cyc", d_cyc, 36 + PD + sh);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      st[u] = 1'b0;
      hd[u] = 1'b0;
      rn[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 4; u++) zero_chk(u, "reset");
    for (int u = 0; u < 4; u++) rn[u] = 1'b1;
    @(negedge clk);

    run_layer(0, 4, 3, 1, 0, 1, 1, 0, -1);
    lit_default(0);

    run_layer(0, 4, 3, 1, 0, 1, 1, 12, -1);
    lit_default(5);

    run_layer(1, 4, 3, 1, 1, 1, 1, 0, -1);
    chk("pad_tap_count", o_ifm.size(), 144);
    chk("pad_first_pz", qat(o_pad, 0), 1);
    chk("pad_tap5_pz", qat(o_pad, 4), 0);
    chk("pad_tap5_ifm", qat(o_ifm, 4), 0);
    chk("pad_px33_i2_pz", qat(o_pad, 141), 1);
    chk("pad_we_count", w_cyc.size(), 16);

    run_layer(2, 5, 3, 2, 0, 1, 1, 0, -1);
    chk("str_tap_count", o_ifm.size(), 36);
    chk("str_px01_ifm", qat(o_ifm, 9), 2);
    chk("str_px10_ifm", qat(o_ifm, 18), 10);

    run_layer(3, 4, 3, 1, 0, 2, 2, 0, -1);
    chk("ch_tap_count", o_ifm.size(), 144);
    chk("ch_tap10_ifm", qat(o_ifm, 9), 16);
    chk("ch_tap10_wgt", qat(o_wgt, 9), 9);
    chk("ch_oc1_wgt", qat(o_wgt, 72), 18);
    chk("ch_we_count", w_cyc.size(), 8);
    for (int k = 4; k < 8; k++) begin
      chk("ch_we_chan", qat(w_ch, k), 1);
      chk("ch_we_addr", qat(w_addr, k), k);
    end

    run_layer(0, 4, 3, 1, 0, 1, 1, 0, 20);
    run_layer(0, 4, 3, 1, 0, 1, 1, 0, -1);
    lit_default(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
